// File: rtl/axi_ddr_pkg.sv
// Shared AXI constants, size helper and write-master state encoding for the
// BRAM<->DDR transfer blocks.
package axi_ddr_pkg;

   localparam logic [1:0] BURST_INCR   = 2'b01;
   localparam logic [3:0] CACHE_NORMAL = 4'b0011;
   localparam logic [1:0] RESP_OKAY    = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_DONE
   } wr_state_e;

   // AxSIZE encoding for a bus of nbytes bytes (log2)
   function automatic logic [2:0] axi_size(input int unsigned nbytes);
      logic [2:0] sz;
      sz = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (nbytes == (32'd1 << i)) sz = 3'(i);
      end
      return sz;
   endfunction

endpackage

// File: rtl/bram_axi_ddr_write_if.sv
// AXI4 write-channel bundle (AW/W/B) between the write master and DDR slave.
interface bram_axi_ddr_write_if #(
   parameter int DDR_DW          = 64,
   parameter int DDR_ADDR_WIDTH  = 29,
   parameter int BURST_LEN_WIDTH = 8
);
   logic [3:0]                 awid;
   logic [DDR_ADDR_WIDTH-1:0]  awaddr;
   logic [BURST_LEN_WIDTH-1:0] awlen;
   logic [2:0]                 awsize;
   logic [1:0]                 awburst;
   logic                       awlock;
   logic [3:0]                 awcache;
   logic [2:0]                 awprot;
   logic [3:0]                 awqos;
   logic                       awvalid;
   logic                       awready;
   logic [DDR_DW-1:0]          wdata;
   logic [DDR_DW/8-1:0]        wstrb;
   logic                       wlast;
   logic                       wvalid;
   logic                       wready;
   logic [3:0]                 bid;
   logic [1:0]                 bresp;
   logic                       bvalid;
   logic                       bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bid, bresp, bvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/pp_skid_fifo2.sv
// Two-entry FIFO used to absorb the one-cycle BRAM read latency so a
// streaming consumer sees back-to-back data.
module pp_skid_fifo2 #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [1:0]       count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push_ok, pop_ok;

   assign full     = (count_q == 2'd2);
   assign empty    = (count_q == 2'd0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // a push into a full FIFO is only legal when the head leaves the same cycle
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_d = ~rd_ptr_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/bram_axi_ddr_write.sv
// AXI4 write master: streams wr_num_burst INCR bursts of BRAM words into DDR,
// one burst at a time, with BRAM prefetch through a 2-entry skid buffer.
//
//   state | meaning
//   IDLE  | wr_ready=1, waiting for wr_start
//   AW    | address phase of current burst, prefetch allowed
//   W     | data beats streaming from the skid buffer
//   B     | waiting for write response
//   DONE  | one-cycle wr_done/wr_err report
module bram_axi_ddr_write
   import axi_ddr_pkg::*;
#(
   parameter int DDR_DW          = 64,
   parameter int DDR_ADDR_WIDTH  = 29,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int NUM_BURST_WIDTH = 8,
   parameter int BRAM_ADDR_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_start,
   input  logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
   input  logic [NUM_BURST_WIDTH-1:0] wr_num_burst,
   input  logic [DDR_ADDR_WIDTH-1:0]  wr_start_addr,
   input  logic [BRAM_ADDR_WIDTH-1:0] wr_start_bram_addr,
   output logic                       wr_ready,
   output logic                       wr_done,
   output logic                       wr_err,
   output logic                       bram_r_en,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_r_addr,
   input  logic [DDR_DW-1:0]          bram_rdata,
   bram_axi_ddr_write_if.master       m_axi
);
   localparam logic [2:0] AW_SIZE = axi_size(DDR_DW / 8);
   localparam int         BLW1    = BURST_LEN_WIDTH + 1;

   wr_state_e                  state_q, state_d;
   logic [DDR_ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
   logic [BURST_LEN_WIDTH-1:0] awlen_q, awlen_d;
   logic [NUM_BURST_WIDTH-1:0] bursts_q, bursts_d;
   logic [BRAM_ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
   logic [BLW1-1:0]            fetch_cnt_q, fetch_cnt_d;
   logic [BLW1-1:0]            beat_cnt_q, beat_cnt_d;
   logic                       rd_inflight_q, rd_inflight_d;
   logic                       err_q, err_d;

   logic [BLW1-1:0]            burst_beats;
   logic [DDR_ADDR_WIDTH-1:0]  burst_bytes;
   logic [1:0]                 fifo_count;
   logic                       fifo_empty;
   logic                       fifo_full_unused;
   logic [DDR_DW-1:0]          fifo_head;
   logic [1:0]                 occ;
   logic [1:0]                 occ_limit;
   logic                       fetch;
   logic                       wvalid;
   logic                       w_hs;
   logic                       last_beat;
   logic                       unused_bid;

   assign burst_beats = {1'b0, awlen_q} + BLW1'(1);
   assign burst_bytes = DDR_ADDR_WIDTH'(burst_beats) << AW_SIZE;

   assign wvalid    = (state_q == ST_W) && !fifo_empty;
   assign w_hs      = wvalid && m_axi.wready;
   assign last_beat = (beat_cnt_q == {1'b0, awlen_q});

   // counting this cycle's pop as free space keeps the stream bubble-free
   assign occ       = fifo_count + {1'b0, rd_inflight_q};
   assign occ_limit = 2'd2 + {1'b0, w_hs};
   assign fetch     = ((state_q == ST_AW) || (state_q == ST_W)) &&
                      (fetch_cnt_q < burst_beats) && (occ < occ_limit);

   pp_skid_fifo2 #(.WIDTH(DDR_DW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_inflight_q),
      .push_data (bram_rdata),
      .pop       (w_hs),
      .pop_data  (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full_unused),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      awaddr_d      = awaddr_q;
      awlen_d       = awlen_q;
      bursts_d      = bursts_q;
      bram_addr_d   = bram_addr_q;
      fetch_cnt_d   = fetch_cnt_q;
      beat_cnt_d    = beat_cnt_q;
      err_d         = err_q;
      rd_inflight_d = fetch;

      if (fetch) begin
         bram_addr_d = bram_addr_q + BRAM_ADDR_WIDTH'(1);
         fetch_cnt_d = fetch_cnt_q + BLW1'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (wr_start) begin
               awaddr_d    = wr_start_addr;
               awlen_d     = wr_burst_len;
               bursts_d    = (wr_num_burst == '0) ? NUM_BURST_WIDTH'(1) : wr_num_burst;
               bram_addr_d = wr_start_bram_addr;
               fetch_cnt_d = '0;
               beat_cnt_d  = '0;
               err_d       = 1'b0;
               state_d     = ST_AW;
            end
         end
         ST_AW: begin
            if (m_axi.awready) state_d = ST_W;
         end
         ST_W: begin
            if (w_hs) begin
               if (last_beat) begin
                  beat_cnt_d = '0;
                  state_d    = ST_B;
               end else begin
                  beat_cnt_d = beat_cnt_q + BLW1'(1);
               end
            end
         end
         ST_B: begin
            if (m_axi.bvalid) begin
               err_d = err_q | (m_axi.bresp != RESP_OKAY);
               if (bursts_q > NUM_BURST_WIDTH'(1)) begin
                  bursts_d    = bursts_q - NUM_BURST_WIDTH'(1);
                  awaddr_d    = awaddr_q + burst_bytes;
                  fetch_cnt_d = '0;
                  state_d     = ST_AW;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         awaddr_q      <= '0;
         awlen_q       <= '0;
         bursts_q      <= '0;
         bram_addr_q   <= '0;
         fetch_cnt_q   <= '0;
         beat_cnt_q    <= '0;
         rd_inflight_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         awaddr_q      <= awaddr_d;
         awlen_q       <= awlen_d;
         bursts_q      <= bursts_d;
         bram_addr_q   <= bram_addr_d;
         fetch_cnt_q   <= fetch_cnt_d;
         beat_cnt_q    <= beat_cnt_d;
         rd_inflight_q <= rd_inflight_d;
         err_q         <= err_d;
      end
   end

   assign wr_ready    = (state_q == ST_IDLE);
   assign wr_done     = (state_q == ST_DONE);
   assign wr_err      = (state_q == ST_DONE) && err_q;
   assign bram_r_en   = fetch;
   assign bram_r_addr = bram_addr_q;

   assign m_axi.awid    = 4'd0;
   assign m_axi.awaddr  = awaddr_q;
   assign m_axi.awlen   = awlen_q;
   assign m_axi.awsize  = AW_SIZE;
   assign m_axi.awburst = BURST_INCR;
   assign m_axi.awlock  = 1'b0;
   assign m_axi.awcache = CACHE_NORMAL;
   assign m_axi.awprot  = 3'd0;
   assign m_axi.awqos   = 4'd0;
   assign m_axi.awvalid = (state_q == ST_AW);
   assign m_axi.wdata   = fifo_head;
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = wvalid && last_beat;
   assign m_axi.wvalid  = wvalid;
   assign m_axi.bready  = (state_q == ST_B);

   assign unused_bid = ^m_axi.bid;
endmodule

// File: tb/tb_bram_axi_ddr_write.sv
// Scoreboard bench for bram_axi_ddr_write: BRAM model, AXI write slave,
// and expected AW/W/done streams compared as the DUT produces them.
module tb_bram_axi_ddr_write;
   localparam int DW = 64;
   localparam int AW = 29;
   localparam int LW = 8;
   localparam int NW = 8;
   localparam int BW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_start = 1'b0;
   logic [LW-1:0] wr_burst_len = '0;
   logic [NW-1:0] wr_num_burst = '0;
   logic [AW-1:0] wr_start_addr = '0;
   logic [BW-1:0] wr_start_bram_addr = '0;
   logic          wr_ready, wr_done, wr_err, bram_r_en;
   logic [BW-1:0] bram_r_addr;
   logic [DW-1:0] bram_rdata;

   bram_axi_ddr_write_if #(.DDR_DW(DW), .DDR_ADDR_WIDTH(AW), .BURST_LEN_WIDTH(LW)) axi ();

   bram_axi_ddr_write #(
      .DDR_DW(DW), .DDR_ADDR_WIDTH(AW), .BURST_LEN_WIDTH(LW),
      .NUM_BURST_WIDTH(NW), .BRAM_ADDR_WIDTH(BW)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .wr_start           (wr_start),
      .wr_burst_len       (wr_burst_len),
      .wr_num_burst       (wr_num_burst),
      .wr_start_addr      (wr_start_addr),
      .wr_start_bram_addr (wr_start_bram_addr),
      .wr_ready           (wr_ready),
      .wr_done            (wr_done),
      .wr_err             (wr_err),
      .bram_r_en          (bram_r_en),
      .bram_r_addr        (bram_r_addr),
      .bram_rdata         (bram_rdata),
      .m_axi              (axi)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [DW-1:0] mem [0:1023];
   logic [AW-1:0] exp_aw_addr [$];
   logic [LW-1:0] exp_aw_len [$];
   logic [DW-1:0] exp_wd [$];
   bit            exp_wl [$];
   bit            exp_err [$];
   logic [1:0]    bresp_q [$];

   int aw_delay = 0;
   bit wr_rand = 0;
   int aw_cnt = 0;
   int b_pending = 0;
   bit b_hs_seen = 0;
   int b_out = 0;
   int done_cnt = 0;
   int beat_idx = 0;
   int burst_start = 0;
   bit aw_stalled = 0;
   bit w_stalled = 0;
   logic [AW-1:0] aw_stall_addr;
   logic [DW-1:0] w_stall_data;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (bram_r_en) bram_rdata <= mem[bram_r_addr];

   // AXI write slave: awready after aw_delay cycles, optional random wready,
   // one B response per completed burst
   initial begin : slave
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      axi.bresp   = 2'b00;
      axi.bid     = 4'h0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            axi.awready = 1'b0;
            axi.bvalid  = 1'b0;
            aw_cnt      = 0;
         end else begin
            if (axi.awvalid) begin
               axi.awready = (aw_cnt >= aw_delay);
               aw_cnt++;
            end else begin
               axi.awready = 1'b0;
               aw_cnt      = 0;
            end
            axi.wready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_hs_seen) begin
               axi.bvalid = 1'b0;
               b_hs_seen  = 0;
            end
            if (!axi.bvalid && b_pending > 0) begin
               axi.bvalid = 1'b1;
               axi.bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
               axi.bid    = 4'h5;
               b_pending--;
            end
         end
      end
   end

   always @(negedge clk) begin : mon
      bit lastexp;
      if (rst_n) begin
         if (aw_stalled) begin
            chk("aw_hold_valid", 64'(axi.awvalid), 64'd1);
            chk("aw_hold_addr", 64'(axi.awaddr), 64'(aw_stall_addr));
         end
         if (w_stalled) begin
            chk("w_hold_valid", 64'(axi.wvalid), 64'd1);
            chk("w_hold_data", axi.wdata, w_stall_data);
         end
         aw_stalled    = axi.awvalid && !axi.awready;
         aw_stall_addr = axi.awaddr;
         w_stalled     = axi.wvalid && !axi.wready;
         w_stall_data  = axi.wdata;

         if (axi.awvalid && axi.awready) begin
            chk("aw_after_b", 64'(b_out), 64'd0);
            if (exp_aw_addr.size() == 0) chk("aw_extra", 64'd1, 64'd0);
            else begin
               chk("awaddr", 64'(axi.awaddr), 64'(exp_aw_addr.pop_front()));
               chk("awlen", 64'(axi.awlen), 64'(exp_aw_len.pop_front()));
               chk("aw_const", 64'({axi.awid, axi.awsize, axi.awburst, axi.awlock,
                                    axi.awcache, axi.awprot, axi.awqos}),
                   64'({4'h0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'h0}));
            end
         end

         if (axi.wvalid && axi.wready) begin
            if (beat_idx == 0) burst_start = cyc;
            if (exp_wd.size() == 0) chk("w_extra", 64'd1, 64'd0);
            else begin
               chk("wdata", axi.wdata, exp_wd.pop_front());
               lastexp = exp_wl.pop_front();
               chk("wlast", 64'(axi.wlast), 64'(lastexp));
            end
            chk("wstrb", 64'(axi.wstrb), 64'hFF);
            if (axi.wlast) begin
               b_out++;
               b_pending++;
               if (!wr_rand) chk("w_gapless", 64'(cyc - burst_start), 64'(beat_idx));
               beat_idx = 0;
            end else begin
               beat_idx++;
            end
         end

         if (axi.bvalid && axi.bready) begin
            b_hs_seen = 1;
            b_out--;
         end

         if (wr_done) begin
            done_cnt++;
            if (exp_err.size() == 0) chk("done_extra", 64'd1, 64'd0);
            else chk("wr_err", 64'(wr_err), 64'(exp_err.pop_front()));
            chk("w_drained", 64'(exp_wd.size()), 64'd0);
         end
      end else begin
         aw_stalled = 0;
         w_stalled  = 0;
      end
   end

   task automatic issue_cmd(input int len, input int num, input logic [AW-1:0] addr,
                            input int baddr, input int errmask);
      int nb;
      int k;
      logic [AW-1:0] a;
      nb = (num == 0) ? 1 : num;
      k  = 0;
      a  = addr;
      for (int b = 0; b < nb; b++) begin
         exp_aw_addr.push_back(a);
         exp_aw_len.push_back(LW'(len));
         for (int i = 0; i <= len; i++) begin
            exp_wd.push_back(mem[(baddr + k) % 1024]);
            exp_wl.push_back(i == len);
            k++;
         end
         bresp_q.push_back(errmask[b] ? 2'b10 : 2'b00);
         a = a + AW'((len + 1) * 8);
      end
      exp_err.push_back(errmask != 0);
      @(posedge clk); #1;
      chk("ready_idle", 64'(wr_ready), 64'd1);
      wr_start           = 1'b1;
      wr_burst_len       = LW'(len);
      wr_num_burst       = NW'(num);
      wr_start_addr      = addr;
      wr_start_bram_addr = BW'(baddr);
      @(posedge clk); #1;
      wr_start = 1'b0;
      chk("ready_busy", 64'(wr_ready), 64'd0);
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 5000) begin
         @(posedge clk);
         n++;
      end
      chk("done_timeout", 64'(done_cnt >= target), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 64'(wr_ready), 64'd1);
      chk({tag, "_ctl"}, 64'({wr_done, wr_err, bram_r_en, axi.awvalid, axi.wvalid,
                             axi.wlast, axi.bready}), 64'd0);
      chk({tag, "_baddr"}, 64'(bram_r_addr), 64'd0);
      chk({tag, "_awaddr"}, 64'(axi.awaddr), 64'd0);
      chk({tag, "_awlen"}, 64'(axi.awlen), 64'd0);
   endtask

   initial begin : main
      int n;
      for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};

      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // single 8-beat burst
      issue_cmd(7, 1, 29'h100, 0, 0);
      wait_done(1);

      // three 4-beat bursts
      issue_cmd(3, 3, 29'h1000, 10, 0);
      wait_done(2);

      // stalled address and random data backpressure
      aw_delay = 5;
      wr_rand  = 1;
      issue_cmd(5, 3, 29'h2000, 100, 0);
      wait_done(3);
      aw_delay = 0;
      wr_rand  = 0;

      // SLVERR on the second burst, then a clean command
      issue_cmd(3, 3, 29'h3000, 200, 3'b010);
      wait_done(4);
      issue_cmd(1, 1, 29'h4000, 300, 0);
      wait_done(5);

      // num=0 is one burst; a start pulse during W is ignored; BRAM address wraps
      issue_cmd(15, 0, 29'h5000, 1020, 0);
      n = 0;
      while (!axi.wvalid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wvalid_seen", 64'(axi.wvalid), 64'd1);
      chk("ready_in_w", 64'(wr_ready), 64'd0);
      wr_start      = 1'b1;
      wr_num_burst  = NW'(4);
      wr_start_addr = 29'h7700;
      @(posedge clk); #1;
      wr_start = 1'b0;
      wait_done(6);
      repeat (20) @(posedge clk);
      #1;
      chk("no_extra_aw", 64'(exp_aw_addr.size()), 64'd0);
      chk("idle_after", 64'({wr_ready, axi.awvalid}), 64'b10);

      // async reset in the middle of the data phase
      issue_cmd(15, 2, 29'h6000, 500, 0);
      n = 0;
      while (exp_wd.size() > 28 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("beats_before_rst", 64'(exp_wd.size() <= 28), 64'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      exp_aw_addr.delete();
      exp_aw_len.delete();
      exp_wd.delete();
      exp_wl.delete();
      exp_err.delete();
      bresp_q.delete();
      b_pending = 0;
      b_hs_seen = 0;
      b_out     = 0;
      beat_idx  = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      issue_cmd(4, 2, 29'h7000, 600, 0);
      wait_done(7);

      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
